// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// ----------------------------------------------------------------------------
// Iterative 32-bit integer multiply/divide unit for a MIPS-style pipeline.
// One operation at a time. Each operation takes 32 shift-add or
// restore-divide iterations, then one sign-fix cycle, then a one-cycle done
// pulse. Results are held in hi/lo until the next operation completes.
//
// Ports
//   clkin        : single clock, rising edge
//   rst          : asynchronous reset, active low
//   start        : begin an operation (accepted in IDLE or DONE only)
//   op           : 00 mult, 01 multu, 10 div, 11 divu
//   a            : multiplicand / dividend (rs)
//   b            : multiplier / divisor (rt)
//   cancel       : synchronous abort (pipeline flush); beats start
//   busy         : high in RUN and FIX
//   done         : one-cycle pulse when hi/lo carry a fresh result
//   hi           : product[63:32] or remainder
//   lo           : product[31:0] or quotient
//   div_by_zero  : last completed op was a divide with b == 0
// ============================================================================
module muldiv_unit (
    input  logic        clkin,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        b_zero_q, b_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbz_q, dbz_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Operand conditioning and per-iteration datapath temporaries
    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic        div_fits;
    logic [31:0] div_trial;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Magnitudes of the incoming operands. Unsigned ops (op[0]=1) pass the
    // raw values through. |0x80000000| is 0x80000000 read as unsigned,
    // which the unsigned datapath handles correctly.
    always_comb begin
        op_signed = ~op[0];
        a_neg     = op_signed & a[31];
        b_neg     = op_signed & b[31];
        a_mag     = a_neg ? (32'd0 - a) : a;
        b_mag     = b_neg ? (32'd0 - b) : b;
    end

    // One iteration of each algorithm, computed from the current accumulator.
    // Multiply: acc = {partial product, remaining multiplier bits}; add the
    // multiplicand into the top half when the low multiplier bit is set, then
    // shift right (the carry becomes bit 63).
    // Divide: acc = {remainder, remaining dividend bits}; shift left one bit
    // and subtract the divisor when it fits, shifting a 1 into the quotient.
    // A zero divisor always "fits", which yields quotient all-ones and
    // remainder equal to the dividend magnitude.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        div_fits  = (acc_q[63:31] >= {1'b0, mcand_q});
        div_trial = acc_q[62:31] - mcand_q;
    end

    // Sign correction of the finished magnitude result. For a signed divide
    // by zero the remainder correction restores the original dividend, so hi
    // reads back a exactly as captured.
    always_comb begin
        prod_fix = neg_lo_q ? (64'd0 - acc_q) : acc_q;
        quot_fix = b_zero_q ? 32'hFFFF_FFFF
                            : (neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
        rem_fix  = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    // Next-state and datapath control. cancel has priority in every state;
    // start is only honoured in IDLE and DONE so nothing queues behind a
    // running operation.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d  = RUN;
                    count_d  = 5'd0;
                    is_div_d = op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = op[1] & a_neg;
                    b_zero_d = op[1] & (b == 32'd0);
                    if (op[1]) begin
                        acc_d   = {32'd0, a_mag};
                        mcand_d = b_mag;
                    end else begin
                        acc_d   = {32'd0, b_mag};
                        mcand_d = a_mag;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        if (div_fits) begin
                            acc_d = {div_trial, acc_q[30:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[62:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_d = FIX;
                    end
                end
            end

            FIX: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (is_div_q) begin
                        hi_d  = rem_fix;
                        lo_d  = quot_fix;
                        dbz_d = b_zero_q;
                    end else begin
                        hi_d  = prod_fix[63:32];
                        lo_d  = prod_fix[31:0];
                        dbz_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // All state, including the registered status outputs, in one block so
    // reset clears everything at once.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 32'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit
// ----------------------------------------------------------------------------
// Directed testbench for muldiv_unit. Each vector carries a hand-computed
// result. Inputs change on the falling edge and outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
// ============================================================================
module tb_muldiv_unit;

    logic        clkin;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checkCount;
    int errorCount;
    int doneAt;
    int busyCycles;
    logic sawDone;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_unit dut (
        .clkin       (clkin),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Count the comparison and report any difference
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present an operation at the current time (a falling edge) and hold it
    // through the next rising edge; operands are then scrambled since the
    // unit must not look at them again.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn,
                                 input logic [31:0] bIn);
        start = 1'b1;
        op    = opIn;
        a     = aIn;
        b     = bIn;
        @(posedge clkin);
        #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'hCAFE_F00D;
    endtask

    // Sample once per falling edge after the accepting edge. k=0 is the
    // cycle right after acceptance; done is expected at k=33. Optionally
    // holds a bogus start during RUN, which must have no effect.
    task automatic waitDone(input bit holdStart);
        doneAt     = -1;
        busyCycles = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clkin);
            if (holdStart && k == 2) begin
                start = 1'b1;
                op    = OP_DIVU;
                a     = 32'd1;
                b     = 32'd1;
            end
            if (holdStart && k == 20) begin
                start = 1'b0;
            end
            if (busy) busyCycles++;
            if (done) begin
                doneAt = k;
                break;
            end
        end
    endtask

    // Issue an op at the current falling edge and check latency and results
    task automatic runOp(input string tag, input logic [1:0] opIn,
                         input logic [31:0] aIn, input logic [31:0] bIn,
                         input logic [31:0] expHi, input logic [31:0] expLo,
                         input logic expDbz, input bit holdStart);
        applyStimulus(opIn, aIn, bIn);
        waitDone(holdStart);
        checkOutput({tag, " latency"}, 64'(doneAt), 64'd33);
        checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'd33);
        checkOutput({tag, " hi"}, {32'd0, hi}, {32'd0, expHi});
        checkOutput({tag, " lo"}, {32'd0, lo}, {32'd0, expLo});
        checkOutput({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, expDbz});
    endtask

    // Watch for a stray done pulse over more than a full operation
    task automatic watchNoDone(input string tag);
        sawDone = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clkin);
            if (done) sawDone = 1'b1;
        end
        checkOutput({tag, " no done"}, {63'd0, sawDone}, 64'd0);
    endtask

    // Every output must read zero while / right after reset
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " busy"}, {63'd0, busy}, 64'd0);
        checkOutput({tag, " done"}, {63'd0, done}, 64'd0);
        checkOutput({tag, " hi"}, {32'd0, hi}, 64'd0);
        checkOutput({tag, " lo"}, {32'd0, lo}, 64'd0);
        checkOutput({tag, " div_by_zero"}, {63'd0, div_by_zero}, 64'd0);
    endtask

    // Main directed sequence
    initial begin
        checkCount = 0;
        errorCount = 0;
        rst        = 1'b0;
        start      = 1'b0;
        cancel     = 1'b0;
        op         = OP_MULT;
        a          = 32'd0;
        b          = 32'd0;

        repeat (2) @(posedge clkin);
        @(negedge clkin);
        checkResetOutputs("power-on reset");

        // First start lands on the first rising edge with reset released
        rst = 1'b1;
        runOp("mult -2*3", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003,
              32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
        @(negedge clkin);
        checkOutput("done single pulse", {63'd0, done}, 64'd0);

        @(negedge clkin);
        runOp("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clkin);
        runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        @(negedge clkin);
        runOp("divu 100/7", OP_DIVU, 32'd100, 32'd7,
              32'd2, 32'd14, 1'b0, 1'b0);
        @(negedge clkin);
        runOp("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        @(negedge clkin);
        runOp("divu by zero", OP_DIVU, 32'h1234_5678, 32'd0,
              32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clkin);
        runOp("mult 2*3", OP_MULT, 32'd2, 32'd3,
              32'd0, 32'd6, 1'b0, 1'b0);
        @(negedge clkin);
        runOp("div -9/0", OP_DIV, 32'hFFFF_FFF7, 32'd0,
              32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // A start held high through RUN must not restart or alter the op
        @(negedge clkin);
        runOp("multu 5*5 held start", OP_MULTU, 32'd5, 32'd5,
              32'd0, 32'd25, 1'b0, 1'b1);

        // Cancel at RUN cycle 10: busy drops, no done, results untouched
        @(negedge clkin);
        applyStimulus(OP_MULTU, 32'd7, 32'd9);
        for (int k = 0; k < 10; k++) @(negedge clkin);
        checkOutput("cancel pre busy", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        @(posedge clkin);
        #1;
        cancel = 1'b0;
        @(negedge clkin);
        checkOutput("cancel busy drop", {63'd0, busy}, 64'd0);
        watchNoDone("cancel run");
        checkOutput("cancel hi kept", {32'd0, hi}, 64'd0);
        checkOutput("cancel lo kept", {32'd0, lo}, 64'd25);

        // cancel together with start in IDLE drops the start
        @(negedge clkin);
        start  = 1'b1;
        cancel = 1'b1;
        op     = OP_MULT;
        a      = 32'd2;
        b      = 32'd2;
        @(posedge clkin);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clkin);
        checkOutput("cancel+start busy", {63'd0, busy}, 64'd0);
        watchNoDone("cancel+start");
        checkOutput("cancel+start lo kept", {32'd0, lo}, 64'd25);

        // Load non-zero results, then pull reset between edges mid-RUN
        @(negedge clkin);
        runOp("divu by zero again", OP_DIVU, 32'h1234_5678, 32'd0,
              32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clkin);
        applyStimulus(OP_MULT, 32'd3, 32'd3);
        for (int k = 0; k < 5; k++) @(negedge clkin);
        #2;
        rst = 1'b0;
        #1;
        checkResetOutputs("async reset");
        @(posedge clkin);
        @(negedge clkin);
        checkResetOutputs("reset held");

        // Release and start on the first rising edge, then issue back-to-back
        // from the DONE cycle
        rst = 1'b1;
        runOp("mult -1*7 after reset", OP_MULT, 32'hFFFF_FFFF, 32'd7,
              32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 1'b0);
        runOp("divu back-to-back", OP_DIVU, 32'd100, 32'd7,
              32'd2, 32'd14, 1'b0, 1'b0);

        @(negedge clkin);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 clkin  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled on the rising edge.
REQ-005 op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 a  input  32  multiplicand or dividend (rs).
REQ-007 b  input  32  multiplier or divisor (rt).
REQ-008 cancel  input  1  synchronous abort from the pipeline flush.
REQ-009 busy  output  1  operation in progress.
REQ-010 done  output  1  one-cycle pulse; hi/lo hold the new result.
REQ-011 hi  output  32  product[63:32] or remainder.
REQ-012 lo  output  32  product[31:0] or quotient.
REQ-013 div_by_zero  output  1  last completed op was div/divu with b==0.

Function
REQ-014 FSM states SHALL be IDLE, RUN, FIX, DONE.
REQ-015 In IDLE or DONE, start=1 and cancel=0 SHALL:
  - capture op;
  - capture |a| and |b| (magnitudes for signed ops, raw for unsigned);
  - record result signs;
  - clear the iteration counter;
  - go to RUN.
REQ-016 start SHALL be ignored in RUN and FIX; no queuing.
REQ-017 RUN SHALL perform exactly one iteration per cycle for 32 cycles, then go to FIX.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
REQ-018 FIX SHALL, in one cycle:
  - apply two's-complement sign correction;
  - load hi/lo;
  - load div_by_zero;
  - go to DONE.
REQ-019 DONE SHALL last one cycle, with done=1, then return to IDLE unless a new start is accepted.
REQ-020 Latency: start sampled at edge N gives done=1 in the cycle after edge N+33; back-to-back issue every 34 cycles.
REQ-021 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-022 Signed multiply SHALL produce the exact 64-bit two's-complement product; multu SHALL produce the exact unsigned product.
REQ-023 Signed divide SHALL truncate the quotient toward zero; the remainder sign SHALL equal the dividend sign.
REQ-024 Signed divide 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no error flag.
REQ-025 Division by zero (signed or unsigned) SHALL:
  - take full latency;
  - give lo=0xFFFFFFFF and hi=a as captured (unmodified);
  - set div_by_zero=1.
REQ-026 Any completed multiply SHALL clear div_by_zero.
REQ-027 cancel=1 in RUN or FIX SHALL go to IDLE next edge, leave hi/lo/div_by_zero unchanged, and produce no done pulse.
REQ-028 cancel=1 together with start in IDLE/DONE SHALL win; start is dropped.
REQ-029 hi/lo SHALL change only on the FIX-to-DONE transition and hold between operations.
REQ-030 Operand inputs SHALL be don't-care except on the accepting edge.

Reset
REQ-031 rst=0 SHALL immediately, regardless of clock, force:
  - state IDLE;
  - busy=0, done=0;
  - hi=0, lo=0, div_by_zero=0;
  - counter and accumulators to 0.
REQ-032 Reset mid-operation SHALL discard the operation with no done pulse.
REQ-033 The first start SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-034 mult a=0xFFFFFFFE (-2), b=0x00000003 -> done at edge N+34 with hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for exactly 33 cycles.
REQ-035 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 The bench SHALL cover three divides:
  - div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=100, b=7 -> lo=14, hi=2.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 divu a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1; a following mult 2*3 -> lo=6, hi=0, div_by_zero=0.
REQ-038 Start multu 5*5, then pulse cancel at RUN cycle 10 -> busy drops next edge, no done pulse, hi/lo keep prior values; a start held during RUN is ignored.
REQ-039 Assert rst=0 between clock edges mid-RUN -> all outputs 0 immediately; start issued in DONE cycle -> next op accepted back-to-back, done again 34 cycles later.
